// File: rtl/z180_reset_seq_pkg.sv
// Shared definitions for the Z8S180 reset sequencer: FSM state codes,
// the default debounce count derived from hwclk, and a counter-width helper.
package z180_reset_seq_pkg;

  // State codes are visible on the state port (LEDs / debug), so they are fixed.
  typedef enum logic [1:0] {
    S_POR    = 2'd0,
    S_RUN    = 2'd1,
    S_ASSERT = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  // hwclk is 25 MHz; 10 ms of debounce is 250000 cycles.
  localparam int HWCLK_HZ                = 25_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = HWCLK_HZ / 100;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/z180_reset_seq_sync_debounce.sv
// Synchroniser plus level debouncer for an active-low asynchronous input.
// A new level is accepted only after it has been seen for DEBOUNCE_CYCLES
// consecutive edges at the synchroniser output; any reversion restarts the count.
module sync_debounce
  import z180_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic hwclk,
  input  logic reset_n,
  input  logic async_n,
  output logic level
);

  localparam int            DW      = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_n;
  logic [DW-1:0]          db_cnt;

  assign sync_n = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; resets to the released (high) level.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_n};
    end
  end

  // Debounce: count while the synchronised level differs, accept at terminal count.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      level  <= 1'b1;
      db_cnt <= '0;
    end else if (sync_n == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      level  <= sync_n;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/z180_reset_seq.sv
// Z8S180 /RESET generator. Holds the CPU in reset for a power-on window after
// reset_n release, for as long as the debounced s1_n button is pressed, and for
// a post-release stretch afterwards. cpu_reset_n and rel_pulse are registered
// from the next-state value so they change in the same cycle the state register does.
module z180_reset_seq
  import z180_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int POR_CYCLES      = 1024,
  parameter int HOLD_CYCLES     = 64
) (
  input  logic       hwclk,
  input  logic       reset_n,
  input  logic       s1_n,
  output logic       cpu_reset_n,
  output logic       btn_pressed,
  output logic       rel_pulse,
  output logic [1:0] state
);

  localparam int            MAX_LAST  = (POR_CYCLES > HOLD_CYCLES) ? POR_CYCLES - 1
                                                                   : HOLD_CYCLES - 1;
  localparam int            CW        = cnt_width(MAX_LAST);
  localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic          db_level;
  state_e        state_q;
  state_e        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] next_cnt;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .hwclk   (hwclk),
    .reset_n (reset_n),
    .async_n (s1_n),
    .level   (db_level)
  );

  assign btn_pressed = ~db_level;
  assign state       = state_q;

  // Next-state and shared-counter logic; a press in S_HOLD beats terminal count.
  always_comb begin
    next_state = state_q;
    next_cnt   = '0;
    case (state_q)
      S_POR: begin
        if (cnt == POR_LAST) begin
          next_state = btn_pressed ? S_ASSERT : S_RUN;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (btn_pressed) begin
          next_state = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (!btn_pressed) begin
          next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (btn_pressed) begin
          next_state = S_ASSERT;
        end else if (cnt == HOLD_LAST) begin
          next_state = S_RUN;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      default: begin
        next_state = S_POR;
      end
    endcase
  end

  // State, counter and registered CPU-facing outputs.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_POR;
      cnt         <= '0;
      cpu_reset_n <= 1'b0;
      rel_pulse   <= 1'b0;
    end else begin
      state_q     <= next_state;
      cnt         <= next_cnt;
      cpu_reset_n <= (next_state == S_RUN);
      rel_pulse   <= (next_state == S_RUN) && (state_q != S_RUN);
    end
  end

endmodule

// File: tb/tb_z180_reset_seq.sv
// Bench for z180_reset_seq with small parameters. Stimulus pushes the expected
// output events {edge number, state, cpu_reset_n, btn_pressed, rel_pulse};
// a monitor pops one entry each time the sampled output vector changes.
module tb_z180_reset_seq;

  localparam int W = 37;

  logic       hwclk;
  logic       reset_n;
  logic       s1_n;
  logic       cpu_reset_n;
  logic       btn_pressed;
  logic       rel_pulse;
  logic [1:0] state;

  logic [W-1:0] exp_q[$];
  int           cyc;
  int           vectors_applied;
  int           miscompares;
  logic [4:0]   prev_vec;

  z180_reset_seq #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .POR_CYCLES      (8),
    .HOLD_CYCLES     (5)
  ) dut (
    .hwclk       (hwclk),
    .reset_n     (reset_n),
    .s1_n        (s1_n),
    .cpu_reset_n (cpu_reset_n),
    .btn_pressed (btn_pressed),
    .rel_pulse   (rel_pulse),
    .state       (state)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    hwclk = 1'b0;
    forever #5 hwclk = ~hwclk;
  end

  // Edge number since the last reset_n release (first edge after release is 1).
  always @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge hwclk);
    #2;
  endtask

  // Expect the output vector to become vec right after edge (cyc + offset).
  task automatic push_exp(input int offset, input logic [1:0] st, input logic cpu,
                          input logic btn, input logic rel);
    logic [31:0] at;
    at = 32'(cyc + offset);
    exp_q.push_back({at, st, cpu, btn, rel});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors_applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Release of a held button pressed in S_ASSERT: btn drops, HOLD, then RUN.
  task automatic release_and_expect();
    s1_n = 1'b1;
    push_exp(6,  2'd2, 1'b0, 1'b0, 1'b0);
    push_exp(7,  2'd3, 1'b0, 1'b0, 1'b0);
    push_exp(12, 2'd1, 1'b1, 1'b0, 1'b1);
    push_exp(13, 2'd1, 1'b1, 1'b0, 1'b0);
  endtask

  // Press while in S_RUN: btn rises, then the FSM enters S_ASSERT.
  task automatic press_and_expect();
    s1_n = 1'b0;
    push_exp(6, 2'd1, 1'b1, 1'b1, 1'b0);
    push_exp(7, 2'd2, 1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge hwclk) begin
    logic [4:0]   cur;
    logic [W-1:0] got;
    logic [W-1:0] want;
    cur = {state, cpu_reset_n, btn_pressed, rel_pulse};
    if (!reset_n) begin
      prev_vec = 5'b0;
    end else if (cur !== prev_vec) begin
      got = {32'(cyc), cur};
      vectors_applied++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got edge %0d vec %b, required no change",
                 cyc, cur);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL event: got edge %0d vec %b, required edge %0d vec %b",
                   cyc, cur, want[W-1:5], want[4:0]);
        end
      end
      prev_vec = cur;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    prev_vec        = 5'b0;
    reset_n         = 1'b0;
    s1_n            = 1'b1;
    wait_cycles(3);

    // Reset values
    check("reset_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("reset_btn_pressed", 32'(btn_pressed), 32'd0);
    check("reset_rel_pulse",   32'(rel_pulse),   32'd0);
    check("reset_state",       32'(state),       32'd0);

    // 1: power-on without button
    reset_n = 1'b1;
    push_exp(8, 2'd1, 1'b1, 1'b0, 1'b1);
    push_exp(9, 2'd1, 1'b1, 1'b0, 1'b0);
    wait_cycles(12);

    // 2: bounce, two 3-cycle lows one cycle apart
    s1_n = 1'b0; wait_cycles(3);
    s1_n = 1'b1; wait_cycles(1);
    s1_n = 1'b0; wait_cycles(3);
    s1_n = 1'b1; wait_cycles(12);
    check("bounce_btn_pressed", 32'(btn_pressed), 32'd0);
    check("bounce_cpu_reset_n", 32'(cpu_reset_n), 32'd1);

    // 3: press in S_RUN
    press_and_expect();
    wait_cycles(10);
    check("press_state", 32'(state), 32'd2);

    // 4: release and post-release stretch
    release_and_expect();
    wait_cycles(16);

    // 5: re-press during S_HOLD, landing on the terminal-count cycle
    press_and_expect();
    wait_cycles(10);
    s1_n = 1'b1;
    push_exp(6,  2'd2, 1'b0, 1'b0, 1'b0);
    push_exp(7,  2'd3, 1'b0, 1'b0, 1'b0);
    push_exp(11, 2'd3, 1'b0, 1'b1, 1'b0);
    push_exp(12, 2'd2, 1'b0, 1'b1, 1'b0);
    wait_cycles(5);
    s1_n = 1'b0;
    wait_cycles(15);
    check("repress_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("repress_state",       32'(state),       32'd2);
    release_and_expect();
    wait_cycles(16);

    // 6a: button held through power-on, async reset mid-S_RUN
    s1_n    = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("async_rst_state",       32'(state),       32'd0);
    check("async_rst_btn_pressed", 32'(btn_pressed), 32'd0);
    wait_cycles(2);
    reset_n = 1'b1;
    push_exp(6, 2'd0, 1'b0, 1'b1, 1'b0);
    push_exp(8, 2'd2, 1'b0, 1'b1, 1'b0);
    wait_cycles(12);
    release_and_expect();
    wait_cycles(16);

    // 6b: reset pulse mid-S_RUN replays the power-on window
    reset_n = 1'b0;
    #1;
    check("pulse_rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("pulse_rst_state",       32'(state),       32'd0);
    check("pulse_rst_rel_pulse",   32'(rel_pulse),   32'd0);
    wait_cycles(2);
    reset_n = 1'b1;
    push_exp(8, 2'd1, 1'b1, 1'b0, 1'b1);
    push_exp(9, 2'd1, 1'b1, 1'b0, 1'b0);
    wait_cycles(12);

    // ---------------- final report ----------------
    while (exp_q.size() != 0) begin
      logic [W-1:0] want;
      want = exp_q.pop_front();
      vectors_applied++;
      miscompares++;
      $display("FAIL missing_event: got nothing, required edge %0d vec %b",
               want[W-1:5], want[4:0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
